// File: rtl/fetch_queue_unit_if.sv
// Issue-side and IMEM-side signal bundle of the fetch front end; master is the fetch unit.
// No flow control of its own: issue consumes via deq_cnt, IMEM is a fixed one-cycle read.
interface fetch_queue_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [1:0]         deq_cnt;
  logic               slot0_valid;
  logic               slot1_valid;
  logic [INSTR_W-1:0] slot0_instr;
  logic [INSTR_W-1:0] slot1_instr;
  logic [PC_W-1:0]    slot0_pc;
  logic [PC_W-1:0]    slot1_pc;
  logic [CNT_W-1:0]   fq_count;
  logic [PC_W-1:0]    fetch_pc;

  modport master (
    output imem_addr, slot0_valid, slot1_valid, slot0_instr, slot1_instr,
           slot0_pc, slot1_pc, fq_count, fetch_pc,
    input  imem_rdata, redirect_valid, redirect_pc, deq_cnt
  );

  modport slave (
    input  imem_addr, slot0_valid, slot1_valid, slot0_instr, slot1_instr,
           slot0_pc, slot1_pc, fq_count, fetch_pc,
    output imem_rdata, redirect_valid, redirect_pc, deq_cnt
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC register, one in-flight synchronous IMEM read, circular queue whose head two entries feed issue.
// Redirect reaches slot0 after 2 cycles (1 with FQ_BYPASS_EN); fetch issues only while queue + in-flight fit in DEPTH.
module fetch_queue_unit #(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_unit_if.master fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_valid_q, inflight_valid_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_nxt1;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];
  logic [PC_W-1:0]    epc_q [DEPTH];
  logic [PC_W-1:0]    epc_d [DEPTH];

  logic       ret_vld;
  logic       fwd_taken;
  logic       push;
  logic       credit_ok;
  logic [1:0] q_deq;

  // Returning word is only usable when this cycle is not redirecting.
  assign ret_vld = inflight_valid_q && !fq.redirect_valid;

`ifdef FQ_BYPASS_EN
  logic fwd0, fwd1;
  assign fwd0      = ret_vld && (count_q == '0);
  assign fwd1      = ret_vld && (count_q == CNT_W'(1));
  assign fwd_taken = (fwd0 && (fq.deq_cnt != 2'd0)) || (fwd1 && (fq.deq_cnt == 2'd2));
`else
  assign fwd_taken = 1'b0;
`endif

  assign push      = ret_vld && !fwd_taken;
  assign q_deq     = fwd_taken ? (fq.deq_cnt - 2'd1) : fq.deq_cnt;
  assign credit_ok = (CRD_W'(count_q) + CRD_W'(inflight_valid_q)) < (CRD_W'(DEPTH) + CRD_W'(fq.deq_cnt));

  assign fq.imem_addr = fq.redirect_valid ? fq.redirect_pc : fetch_pc_q;
  assign fq.fq_count  = count_q;
  assign fq.fetch_pc  = fetch_pc_q;

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    instr_d          = instr_q;
    epc_d            = epc_q;

    if (fq.redirect_valid) begin
      count_d          = '0;
      rd_ptr_d         = wr_ptr_q;
      inflight_valid_d = 1'b1;
      inflight_pc_d    = fq.redirect_pc;
      fetch_pc_d       = fq.redirect_pc + PC_W'(1);
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = fq.imem_rdata;
        epc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(q_deq);
      count_d  = count_q + CNT_W'(push) - CNT_W'(q_deq);
      if (credit_ok) begin
        inflight_valid_d = 1'b1;
        inflight_pc_d    = fetch_pc_q;
        fetch_pc_d       = fetch_pc_q + PC_W'(1);
      end else begin
        inflight_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    rd_ptr_nxt1    = rd_ptr_q + PTR_W'(1);
    fq.slot0_valid = (count_q != '0);
    fq.slot0_instr = instr_q[rd_ptr_q];
    fq.slot0_pc    = epc_q[rd_ptr_q];
    fq.slot1_valid = (count_q >= CNT_W'(2));
    fq.slot1_instr = instr_q[rd_ptr_nxt1];
    fq.slot1_pc    = epc_q[rd_ptr_nxt1];
`ifdef FQ_BYPASS_EN
    // Forward into the first empty slot position only.
    if (fwd0) begin
      fq.slot0_valid = 1'b1;
      fq.slot0_instr = fq.imem_rdata;
      fq.slot0_pc    = inflight_pc_q;
    end
    if (fwd1) begin
      fq.slot1_valid = 1'b1;
      fq.slot1_instr = fq.imem_rdata;
      fq.slot1_pc    = inflight_pc_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q       <= PC_W'(RESET_PC);
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      instr_q          <= instr_d;
      epc_q            <= epc_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus random deq/redirect against a PC-stream scoreboard.
// Expected stream: consumed slots follow PC, PC+1, ... from reset or the last redirect target, instr = 0x1000_0000 + pc.
module tb_fetch_queue_unit;
  localparam int          PC_W     = 8;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam int unsigned RESET_PC = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;
  logic [PC_W-1:0] exp_pc;

  fetch_queue_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) fq ();

  fetch_queue_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return 32'h1000_0000 + INSTR_W'(a);
  endfunction

  // Synchronous IMEM: word for last cycle's address.
  always @(posedge clk) fq.imem_rdata <= mem_word(fq.imem_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc = '0;
    fq.deq_cnt = 2'd0;
    cyc(); cyc();
    #1;
    checks++; if (fq.slot0_valid !== 1'b0) $display("FAIL reset_slot0_valid got %b want 0", fq.slot0_valid); else passed++;
    checks++; if (fq.slot1_valid !== 1'b0) $display("FAIL reset_slot1_valid got %b want 0", fq.slot1_valid); else passed++;
    checks++; if (fq.slot0_instr !== 32'h0) $display("FAIL reset_slot0_instr got %h want 0", fq.slot0_instr); else passed++;
    checks++; if (fq.slot1_pc !== 8'h0) $display("FAIL reset_slot1_pc got %h want 0", fq.slot1_pc); else passed++;
    checks++; if (fq.fq_count !== 3'd0) $display("FAIL reset_fq_count got %0d want 0", fq.fq_count); else passed++;
    checks++; if (fq.imem_addr !== PC_W'(RESET_PC)) $display("FAIL reset_imem_addr got %h want %h", fq.imem_addr, PC_W'(RESET_PC)); else passed++;
  endtask

  task automatic test_fill();
    reset = 1'b0;
    exp_pc = PC_W'(RESET_PC);
    repeat (5) cyc();
    checks++; if (fq.fq_count !== 3'd4) $display("FAIL fill_count got %0d want 4", fq.fq_count); else passed++;
    checks++; if (fq.slot0_pc !== 8'h00 || fq.slot0_instr !== 32'h1000_0000)
      $display("FAIL fill_slot0 got pc %h instr %h want pc 00 instr 10000000", fq.slot0_pc, fq.slot0_instr); else passed++;
    checks++; if (fq.slot1_pc !== 8'h01 || fq.slot1_instr !== 32'h1000_0001)
      $display("FAIL fill_slot1 got pc %h instr %h want pc 01 instr 10000001", fq.slot1_pc, fq.slot1_instr); else passed++;
    checks++; if (fq.fetch_pc !== 8'h04) $display("FAIL fill_fetch_pc got %h want 04", fq.fetch_pc); else passed++;
    cyc();
    checks++; if (fq.imem_addr !== 8'h04 || fq.fq_count !== 3'd4)
      $display("FAIL fill_hold got addr %h count %0d want addr 04 count 4", fq.imem_addr, fq.fq_count); else passed++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      fq.deq_cnt = 2'd1;
      #1;
      checks++; if (fq.slot0_valid !== 1'b1) $display("FAIL stream_gap cycle %0d got valid %b want 1", i, fq.slot0_valid); else passed++;
      checks++; if (fq.slot0_pc !== exp_pc || fq.slot0_instr !== mem_word(exp_pc))
        $display("FAIL stream_slot0 got pc %h instr %h want pc %h instr %h", fq.slot0_pc, fq.slot0_instr, exp_pc, mem_word(exp_pc)); else passed++;
      checks++; if (fq.fq_count !== ((i == 0) ? 3'd4 : 3'd3))
        $display("FAIL stream_count cycle %0d got %0d want %0d", i, fq.fq_count, (i == 0) ? 4 : 3); else passed++;
      exp_pc = exp_pc + 8'd1;
      cyc();
    end
  endtask

  task automatic test_redirect();
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 8'h40;
    fq.deq_cnt = 2'd1;
    #1;
    checks++; if (fq.imem_addr !== 8'h40) $display("FAIL redir_imem_addr got %h want 40", fq.imem_addr); else passed++;
    cyc();
    fq.redirect_valid = 1'b0;
    fq.deq_cnt = 2'd0;
    #1;
    checks++; if (fq.fq_count !== 3'd0) $display("FAIL redir_t1_count got %0d want 0", fq.fq_count); else passed++;
    checks++; if (fq.fetch_pc !== 8'h41) $display("FAIL redir_t1_fetch_pc got %h want 41", fq.fetch_pc); else passed++;
    checks++; if (fq.slot1_valid !== 1'b0) $display("FAIL redir_t1_slot1_valid got %b want 0", fq.slot1_valid); else passed++;
`ifdef FQ_BYPASS_EN
    checks++; if (fq.slot0_valid !== 1'b1 || fq.slot0_pc !== 8'h40)
      $display("FAIL redir_t1_bypass got valid %b pc %h want 1 40", fq.slot0_valid, fq.slot0_pc); else passed++;
`else
    checks++; if (fq.slot0_valid !== 1'b0) $display("FAIL redir_t1_slot0_valid got %b want 0", fq.slot0_valid); else passed++;
`endif
    cyc();
    checks++; if (fq.slot0_valid !== 1'b1 || fq.slot0_pc !== 8'h40 || fq.slot0_instr !== mem_word(8'h40))
      $display("FAIL redir_t2_slot0 got valid %b pc %h instr %h want 1 40 %h", fq.slot0_valid, fq.slot0_pc, fq.slot0_instr, mem_word(8'h40)); else passed++;
    checks++; if (fq.fq_count !== 3'd1) $display("FAIL redir_t2_count got %0d want 1", fq.fq_count); else passed++;
    exp_pc = 8'h40;
  endtask

  task automatic test_dual();
    int   consumed;
    int   start_cnt;
    logic seen1, seen0;
    logic [PC_W-1:0] p1;
    consumed = 0; seen1 = 1'b0; seen0 = 1'b0;
    fq.deq_cnt = 2'd0;
    repeat (5) cyc();
    start_cnt = int'(fq.fq_count);
    for (int i = 0; i < 40; i++) begin
      fq.deq_cnt = fq.slot1_valid ? 2'd2 : (fq.slot0_valid ? 2'd1 : 2'd0);
      #1;
      if (fq.slot1_valid) seen1 = 1'b1; else seen0 = 1'b1;
      checks++; if (fq.fq_count > 3'(DEPTH)) $display("FAIL dual_overflow got %0d want <= %0d", fq.fq_count, DEPTH); else passed++;
      if (fq.deq_cnt != 2'd0) begin
        checks++; if (fq.slot0_pc !== exp_pc || fq.slot0_instr !== mem_word(exp_pc))
          $display("FAIL dual_slot0 got pc %h instr %h want pc %h instr %h", fq.slot0_pc, fq.slot0_instr, exp_pc, mem_word(exp_pc)); else passed++;
        exp_pc = exp_pc + 8'd1;
      end
      if (fq.deq_cnt == 2'd2) begin
        p1 = exp_pc;
        checks++; if (fq.slot1_pc !== p1 || fq.slot1_instr !== mem_word(p1))
          $display("FAIL dual_slot1 got pc %h instr %h want pc %h instr %h", fq.slot1_pc, fq.slot1_instr, p1, mem_word(p1)); else passed++;
        exp_pc = exp_pc + 8'd1;
      end
      consumed += int'(fq.deq_cnt);
      cyc();
    end
    fq.deq_cnt = 2'd0;
    checks++; if (consumed > 40 + start_cnt + 1 || consumed < 40)
      $display("FAIL dual_rate got %0d consumed want %0d..%0d", consumed, 40, 41 + start_cnt); else passed++;
    checks++; if (!(seen1 && seen0)) $display("FAIL dual_slot1_toggle got seen1 %b seen0 %b want 1 1", seen1, seen0); else passed++;
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] seq [4];
    int got;
    seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h01;
    got = 0;
    fq.deq_cnt = 2'd0;
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 8'hFE;
    cyc();
    fq.redirect_valid = 1'b0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      fq.deq_cnt = fq.slot0_valid ? 2'd1 : 2'd0;
      #1;
      if (fq.slot0_valid) begin
        checks++; if (fq.slot0_pc !== seq[got] || fq.slot0_instr !== mem_word(seq[got]))
          $display("FAIL wrap_seq[%0d] got pc %h instr %h want pc %h", got, fq.slot0_pc, fq.slot0_instr, seq[got]); else passed++;
        got++;
      end
      cyc();
    end
    fq.deq_cnt = 2'd0;
    checks++; if (got != 4) $display("FAIL wrap_budget got %0d slots want 4", got); else passed++;
    exp_pc = 8'h02;
  endtask

  task automatic test_random();
    logic post_redir;
    int   nv;
    logic [PC_W-1:0] p1;
    post_redir = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fq.redirect_valid = ($urandom_range(0, 11) == 0);
      fq.redirect_pc = PC_W'($urandom_range(0, 255));
      #1;
      nv = fq.slot1_valid ? 2 : (fq.slot0_valid ? 1 : 0);
      fq.deq_cnt = 2'($urandom_range(0, nv));
      #1;
      checks++; if (fq.fq_count > 3'(DEPTH)) $display("FAIL rand_overflow got %0d want <= %0d", fq.fq_count, DEPTH); else passed++;
      if (post_redir) begin
        checks++; if (fq.fq_count !== 3'd0) $display("FAIL rand_flush_count got %0d want 0", fq.fq_count); else passed++;
      end
`ifdef FQ_BYPASS_EN
      if (fq.fq_count >= 3'd1) begin
        checks++; if (fq.slot0_valid !== 1'b1) $display("FAIL rand_slot0_valid got %b want 1", fq.slot0_valid); else passed++;
      end
`else
      checks++; if (fq.slot0_valid !== (fq.fq_count >= 3'd1) || fq.slot1_valid !== (fq.fq_count >= 3'd2))
        $display("FAIL rand_valids got %b%b want count %0d", fq.slot1_valid, fq.slot0_valid, fq.fq_count); else passed++;
`endif
      if (!fq.redirect_valid) begin
        if (fq.deq_cnt != 2'd0) begin
          checks++; if (fq.slot0_pc !== exp_pc || fq.slot0_instr !== mem_word(exp_pc))
            $display("FAIL rand_slot0 got pc %h instr %h want pc %h instr %h", fq.slot0_pc, fq.slot0_instr, exp_pc, mem_word(exp_pc)); else passed++;
          exp_pc = exp_pc + 8'd1;
        end
        if (fq.deq_cnt == 2'd2) begin
          p1 = exp_pc;
          checks++; if (fq.slot1_pc !== p1 || fq.slot1_instr !== mem_word(p1))
            $display("FAIL rand_slot1 got pc %h instr %h want pc %h instr %h", fq.slot1_pc, fq.slot1_instr, p1, mem_word(p1)); else passed++;
          exp_pc = exp_pc + 8'd1;
        end
      end else begin
        exp_pc = fq.redirect_pc;
      end
      post_redir = fq.redirect_valid;
      cyc();
    end
    fq.redirect_valid = 1'b0;
    fq.deq_cnt = 2'd0;
  endtask

  task automatic test_async_reset();
    repeat (6) cyc();
    fq.deq_cnt = 2'd1;
    cyc();
    checks++; if (fq.slot0_valid !== 1'b1) $display("FAIL areset_pre_valid got %b want 1", fq.slot0_valid); else passed++;
    #2;
    fq.deq_cnt = 2'd0;
    reset = 1'b1;
    #1;
    checks++; if (fq.slot0_valid !== 1'b0 || fq.slot1_valid !== 1'b0)
      $display("FAIL areset_valids got %b%b want 00", fq.slot1_valid, fq.slot0_valid); else passed++;
    checks++; if (fq.fq_count !== 3'd0) $display("FAIL areset_count got %0d want 0", fq.fq_count); else passed++;
    checks++; if (fq.slot0_instr !== 32'h0 || fq.slot0_pc !== 8'h0 || fq.slot1_instr !== 32'h0 || fq.slot1_pc !== 8'h0)
      $display("FAIL areset_contents got %h/%h %h/%h want zeros", fq.slot0_instr, fq.slot0_pc, fq.slot1_instr, fq.slot1_pc); else passed++;
    checks++; if (fq.imem_addr !== PC_W'(RESET_PC)) $display("FAIL areset_imem_addr got %h want %h", fq.imem_addr, PC_W'(RESET_PC)); else passed++;
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    checks++; if (fq.fq_count !== 3'd4 || fq.slot0_pc !== PC_W'(RESET_PC) || fq.slot0_instr !== mem_word(PC_W'(RESET_PC)))
      $display("FAIL areset_restart got count %0d pc %h instr %h want 4 %h %h", fq.fq_count, fq.slot0_pc, fq.slot0_instr,
               PC_W'(RESET_PC), mem_word(PC_W'(RESET_PC))); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached with %0d/%0d checks passed", passed, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_dual();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
